// File: rtl/ddram_arb_pkg.sv
// Shared types and helpers for the DDR3 two-requester arbiter.
package ddram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  typedef enum logic {
    GRANT_RD,
    GRANT_WR
  } grant_t;

  localparam logic [7:0] BURST_ONE = 8'd1;
  localparam int         TAG_W     = 25;

  // Two adjacent byte enables for the 16-bit lane inside the 64-bit qword.
  function automatic logic [7:0] be_for_lane(input logic [1:0] lane);
    return 8'b0000_0011 << {lane, 1'b0};
  endfunction

endpackage

// File: rtl/ddram_arb_if.sv
// Requester toggle handshakes plus the Avalon-style DDR3 port, bundled together.
interface ddram_arb_if;
  logic [24:0] wraddr;
  logic [15:0] din;
  logic        we_req;
  logic        we_ack;
  logic [27:0] rdaddr;
  logic        rd_req;
  logic        rd_ack;
  logic [63:0] dout;

  logic        DDRAM_BUSY;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic [28:0] DDRAM_ADDR;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        DDRAM_RD;
  logic        DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;

  // Arbiter side: serves the requesters and drives the DDR3 command pins.
  modport slave (
    input  wraddr, din, we_req, rdaddr, rd_req,
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output we_ack, rd_ack, dout,
    output DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
  );

  // Environment side: requesters plus the DDR3 controller.
  modport master (
    output wraddr, din, we_req, rdaddr, rd_req,
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  we_ack, rd_ack, dout,
    input  DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
  );
endinterface

// File: rtl/ddram_rd_cache.sv
// One-entry qword read cache: fill on read return, invalidate on a matching write.
module ddram_rd_cache
  import ddram_arb_pkg::*;
(
  input  logic             clk_ram,
  input  logic             reset_n,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [63:0]      data,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_data,
  input  logic             inval,
  input  logic [TAG_W-1:0] inval_tag
);

  logic             valid_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [63:0]      data_reg;

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_tag;
      data_reg  <= fill_data;
    end else if (inval && valid_reg && (tag_reg == inval_tag)) begin
      valid_reg <= 1'b0;
    end
  end

  assign hit  = valid_reg && (tag_reg == lookup_tag);
  assign data = data_reg;

endmodule

// File: rtl/ddram_arb.sv
// Round-robin arbiter sharing one 64-bit DDR3 port between a 16-bit writer and a qword reader.
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter logic [28:0] BASE_QW  = 29'h0600_0000,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic        clk_ram,
  input  logic        reset_n,
  ddram_arb_if.slave  bus
);

  state_t      state_reg,      state_next;
  grant_t      last_grant_reg, last_grant_next;
  logic        we_ack_reg,     we_ack_next;
  logic        rd_ack_reg,     rd_ack_next;
  logic [63:0] dout_reg,       dout_next;
  logic        ddram_rd_reg,   ddram_rd_next;
  logic        ddram_we_reg,   ddram_we_next;
  logic [28:0] ddram_addr_reg, ddram_addr_next;
  logic [63:0] ddram_din_reg,  ddram_din_next;
  logic [7:0]  ddram_be_reg,   ddram_be_next;

  logic             wr_pend, rd_pend, grant_wr;
  logic             cache_hit, cache_fill, cache_inval;
  logic [63:0]      cache_data;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             unused_addr_bits;

  assign wr_pend  = bus.we_req ^ we_ack_reg;
  assign rd_pend  = bus.rd_req ^ rd_ack_reg;
  assign grant_wr = wr_pend && (!rd_pend || (last_grant_reg == GRANT_RD));
  assign rd_tag   = bus.rdaddr[27:3];
  assign wr_tag   = {3'b000, bus.wraddr[24:3]};
  assign unused_addr_bits = ^{bus.wraddr[0], bus.rdaddr[2:0]};

  generate
    if (CACHE_EN) begin : g_cache
      ddram_rd_cache u_cache (
        .clk_ram    (clk_ram),
        .reset_n    (reset_n),
        .lookup_tag (rd_tag),
        .hit        (cache_hit),
        .data       (cache_data),
        .fill       (cache_fill),
        .fill_tag   (rd_tag),
        .fill_data  (bus.DDRAM_DOUT),
        .inval      (cache_inval),
        .inval_tag  (wr_tag)
      );
    end else begin : g_no_cache
      assign cache_hit  = 1'b0;
      assign cache_data = '0;
    end
  endgenerate

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_RD;
      we_ack_reg     <= 1'b0;
      rd_ack_reg     <= 1'b0;
      dout_reg       <= '0;
      ddram_rd_reg   <= 1'b0;
      ddram_we_reg   <= 1'b0;
      ddram_addr_reg <= '0;
      ddram_din_reg  <= '0;
      ddram_be_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      we_ack_reg     <= we_ack_next;
      rd_ack_reg     <= rd_ack_next;
      dout_reg       <= dout_next;
      ddram_rd_reg   <= ddram_rd_next;
      ddram_we_reg   <= ddram_we_next;
      ddram_addr_reg <= ddram_addr_next;
      ddram_din_reg  <= ddram_din_next;
      ddram_be_reg   <= ddram_be_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    we_ack_next     = we_ack_reg;
    rd_ack_next     = rd_ack_reg;
    dout_next       = dout_reg;
    ddram_rd_next   = ddram_rd_reg;
    ddram_we_next   = ddram_we_reg;
    ddram_addr_next = ddram_addr_reg;
    ddram_din_next  = ddram_din_reg;
    ddram_be_next   = ddram_be_reg;
    cache_fill      = 1'b0;
    cache_inval     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_wr) begin
          last_grant_next = GRANT_WR;
          ddram_addr_next = BASE_QW + {7'b0, bus.wraddr[24:3]};
          ddram_din_next  = {4{bus.din}};
          ddram_be_next   = be_for_lane(bus.wraddr[2:1]);
          ddram_we_next   = 1'b1;
          state_next      = WR_ISSUE;
        end else if (rd_pend) begin
          last_grant_next = GRANT_RD;
          if (cache_hit) begin
            // dout already carries this qword; answering in IDLE skips DDR3 entirely
            rd_ack_next = ~rd_ack_reg;
            dout_next   = cache_data;
          end else begin
            ddram_addr_next = BASE_QW + {4'b0, rd_tag};
            ddram_rd_next   = 1'b1;
            state_next      = RD_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        if (!bus.DDRAM_BUSY) begin
          ddram_we_next = 1'b0;
          we_ack_next   = ~we_ack_reg;
          cache_inval   = 1'b1;
          state_next    = IDLE;
        end
      end
      RD_ISSUE: begin
        if (!bus.DDRAM_BUSY) begin
          ddram_rd_next = 1'b0;
          state_next    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.DDRAM_DOUT_READY) begin
          dout_next   = bus.DDRAM_DOUT;
          cache_fill  = 1'b1;
          rd_ack_next = ~rd_ack_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.we_ack         = we_ack_reg;
  assign bus.rd_ack         = rd_ack_reg;
  assign bus.dout           = dout_reg;
  assign bus.DDRAM_ADDR     = ddram_addr_reg;
  assign bus.DDRAM_BURSTCNT = BURST_ONE;
  assign bus.DDRAM_RD       = ddram_rd_reg;
  assign bus.DDRAM_WE       = ddram_we_reg;
  assign bus.DDRAM_DIN      = ddram_din_reg;
  assign bus.DDRAM_BE       = ddram_be_reg;

endmodule

// File: tb/tb_ddram_arb.sv
// Directed self-checking bench for ddram_arb: writes, cached/uncached reads, arbitration, reset.
module tb_ddram_arb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ddram_arb_if bus ();

  ddram_arb dut (
    .clk_ram (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Command monitor: counts read commands, logs grant order, flags RD/WE overlap.
  logic rd_prev = 1'b0;
  logic we_prev = 1'b0;
  int   rd_cmds = 0;
  logic overlap = 1'b0;
  logic grant_log[$];

  always @(negedge clk) begin
    if (bus.DDRAM_RD && bus.DDRAM_WE) overlap <= 1'b1;
    if (bus.DDRAM_RD && !rd_prev) begin
      rd_cmds <= rd_cmds + 1;
      grant_log.push_back(1'b0);
    end
    if (bus.DDRAM_WE && !we_prev) grant_log.push_back(1'b1);
    rd_prev <= bus.DDRAM_RD;
    we_prev <= bus.DDRAM_WE;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  n;
    int  cnt;
    bit  done;

    reset_n              = 1'b0;
    bus.wraddr           = '0;
    bus.din              = '0;
    bus.we_req           = 1'b0;
    bus.rdaddr           = '0;
    bus.rd_req           = 1'b0;
    bus.DDRAM_BUSY       = 1'b0;
    bus.DDRAM_DOUT       = '0;
    bus.DDRAM_DOUT_READY = 1'b0;
    repeat (2) tick();

    check("rst_we_ack",   bus.we_ack, 0);
    check("rst_rd_ack",   bus.rd_ack, 0);
    check("rst_dout",     bus.dout, 0);
    check("rst_rd",       bus.DDRAM_RD, 0);
    check("rst_we",       bus.DDRAM_WE, 0);
    check("rst_addr",     bus.DDRAM_ADDR, 0);
    check("rst_din",      bus.DDRAM_DIN, 0);
    check("rst_be",       bus.DDRAM_BE, 0);
    check("burstcnt",     bus.DDRAM_BURSTCNT, 1);
    reset_n = 1'b1;
    tick();

    // Single write, lane 3
    bus.wraddr = 25'h000006;
    bus.din    = 16'hA55A;
    bus.we_req = ~bus.we_req;
    tick();
    check("wr_we",       bus.DDRAM_WE, 1);
    check("wr_addr",     bus.DDRAM_ADDR, 29'h0600_0000);
    check("wr_be",       bus.DDRAM_BE, 8'hC0);
    check("wr_din",      bus.DDRAM_DIN, 64'hA55A_A55A_A55A_A55A);
    check("wr_ack_wait", bus.we_ack, 0);
    tick();
    check("wr_we_drop",  bus.DDRAM_WE, 0);
    check("wr_ack",      bus.we_ack, 1);

    // Read miss with BUSY held for three cycles
    bus.DDRAM_BUSY = 1'b1;
    bus.rdaddr     = 28'h0000010;
    bus.rd_req     = ~bus.rd_req;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.DDRAM_BUSY = 1'b0;
      tick();
      if (bus.DDRAM_RD) cyc++;
      if (i == 0) check("rd_addr", bus.DDRAM_ADDR, 29'h0600_0002);
    end
    check("rd_hold_cycles", cyc, 4);
    check("rd_dropped",     bus.DDRAM_RD, 0);
    repeat (4) tick();
    check("rd_ack_wait",    bus.rd_ack, 0);
    bus.DDRAM_DOUT       = 64'h0123_4567_89AB_CDEF;
    bus.DDRAM_DOUT_READY = 1'b1;
    tick();
    bus.DDRAM_DOUT_READY = 1'b0;
    check("rd_dout", bus.dout, 64'h0123_4567_89AB_CDEF);
    check("rd_ack",  bus.rd_ack, 1);

    // Repeat read of the same qword: cache hit
    n = rd_cmds;
    bus.DDRAM_DOUT = 64'hDEAD_DEAD_DEAD_DEAD;
    bus.rd_req = ~bus.rd_req;
    tick();
    check("hit_ack",   bus.rd_ack, 0);
    check("hit_dout",  bus.dout, 64'h0123_4567_89AB_CDEF);
    check("hit_rd",    bus.DDRAM_RD, 0);
    tick();
    check("hit_no_cmd", rd_cmds, n);

    // Write into the cached qword, then read it back: must miss
    bus.wraddr = 25'h000010;
    bus.din    = 16'h1234;
    bus.we_req = ~bus.we_req;
    tick();
    tick();
    check("inv_wr_ack", bus.we_ack, 0);
    n = rd_cmds;
    bus.rd_req = ~bus.rd_req;
    tick();
    check("inv_rd_issued", bus.DDRAM_RD, 1);
    tick();
    bus.DDRAM_DOUT       = 64'hFEDC_BA98_7654_3210;
    bus.DDRAM_DOUT_READY = 1'b1;
    tick();
    bus.DDRAM_DOUT_READY = 1'b0;
    check("inv_dout",   bus.dout, 64'hFEDC_BA98_7654_3210);
    check("inv_rd_ack", bus.rd_ack, 1);
    check("inv_rd_cmd", rd_cmds, n + 1);

    // Fresh reset so arbitration starts from last_grant=READ
    reset_n    = 1'b0;
    bus.we_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Simultaneous requests, four rounds
    grant_log.delete();
    for (int it = 0; it < 4; it++) begin
      bus.wraddr     = 25'(32'h100 + it * 8);
      bus.din        = 16'(it + 1);
      bus.rdaddr     = 28'(32'h400 + it * 8);
      bus.DDRAM_DOUT = {32'hCAFE_0000, 32'(it)};
      bus.we_req     = ~bus.we_req;
      bus.rd_req     = ~bus.rd_req;
      cnt  = -1;
      done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
        tick();
        if (bus.DDRAM_RD) cnt = 2;
        else if (cnt > 0) cnt--;
        if (cnt == 0) begin
          bus.DDRAM_DOUT_READY = 1'b1;
          cnt = -1;
        end else begin
          bus.DDRAM_DOUT_READY = 1'b0;
        end
        done = (bus.we_ack == bus.we_req) && (bus.rd_ack == bus.rd_req);
      end
      bus.DDRAM_DOUT_READY = 1'b0;
      check($sformatf("arb%0d_done", it), done, 1);
      check($sformatf("arb%0d_dout", it), bus.dout, {32'hCAFE_0000, 32'(it)});
    end
    check("grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size())
        check($sformatf("grant%0d_is_wr", i), grant_log[i], (i % 2 == 0) ? 1 : 0);
    end

    // Reset while a read is stuck in RD_ISSUE
    bus.DDRAM_BUSY = 1'b1;
    bus.rdaddr     = 28'h0000800;
    bus.rd_req     = ~bus.rd_req;
    tick();
    check("rst_mid_rd_on", bus.DDRAM_RD, 1);
    tick();
    reset_n    = 1'b0;
    bus.rd_req = 1'b0;
    bus.we_req = 1'b0;
    #1;
    check("rst_mid_rd",     bus.DDRAM_RD, 0);
    check("rst_mid_we",     bus.DDRAM_WE, 0);
    check("rst_mid_rd_ack", bus.rd_ack, 0);
    check("rst_mid_we_ack", bus.we_ack, 0);
    check("rst_mid_dout",   bus.dout, 0);
    tick();
    reset_n              = 1'b1;
    bus.DDRAM_BUSY       = 1'b0;
    bus.DDRAM_DOUT       = 64'h5555_AAAA_5555_AAAA;
    bus.DDRAM_DOUT_READY = 1'b1;
    tick();
    bus.DDRAM_DOUT_READY = 1'b0;
    check("late_rdy_ack",  bus.rd_ack, 0);
    check("late_rdy_dout", bus.dout, 0);
    tick();
    check("late_rdy_rd",   bus.DDRAM_RD, 0);

    check("rd_we_exclusive", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
